// File: rtl/mult_div_unit_if.sv
// Start/finish handshake between the control unit (master) and the
// multicycle mult/div engine (slave).
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output mult_start, div_start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  mult_start, div_start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes plus a sign-fix cycle) responding to a start/done handshake.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mult_div_unit_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MULT, DIV, DFIX, DIVZ} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic             q_m1, q_m1_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic [WIDTH-1:0] hi_q, hi_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             dz_q, dz_nxt;

    logic             last_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   m_ext, booth_sum, rem_sh, trial;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

    // Step arithmetic: acc is one bit wider so Booth never overflows on -2^(W-1)
    always_comb begin
        m_ext = {mcand[WIDTH-1], mcand};
        unique case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        rem_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
        trial  = rem_sh - {1'b0, mcand};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.mult_start)     state_nxt = MULT;
                else if (bus.div_start) state_nxt = (bus.b == '0) ? DIVZ : DIV;
            end
            MULT:    if (last_step) state_nxt = IDLE;
            DIV:     if (last_step) state_nxt = DFIX;
            DFIX:    state_nxt = IDLE;
            DIVZ:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        q_nxt     = q;
        mcand_nxt = mcand;
        q_m1_nxt  = q_m1;
        neg_q_nxt = neg_q;
        neg_r_nxt = neg_r;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        dz_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mult_start) begin
                    acc_nxt   = '0;
                    q_nxt     = bus.b;
                    q_m1_nxt  = 1'b0;
                    mcand_nxt = bus.a;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end else if (bus.div_start) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    acc_nxt   = '0;
                    q_nxt     = a_mag;
                    mcand_nxt = b_mag;
                    neg_q_nxt = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_r_nxt = bus.a[WIDTH-1];
                end
            end
            MULT: begin
                acc_nxt  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_nxt    = {booth_sum[0], q[WIDTH-1:1]};
                q_m1_nxt = q[0];
                cnt_nxt  = cnt + CNT_W'(1);
                if (last_step) begin
                    hi_nxt   = booth_sum[WIDTH:1];
                    lo_nxt   = {booth_sum[0], q[WIDTH-1:1]};
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            DIV: begin
                // Restore when the trial subtraction goes negative
                if (trial[WIDTH]) begin
                    acc_nxt = rem_sh;
                    q_nxt   = {q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_nxt = trial;
                    q_nxt   = {q[WIDTH-2:0], 1'b1};
                end
                cnt_nxt = cnt + CNT_W'(1);
            end
            DFIX: begin
                lo_nxt   = neg_q ? -q : q;
                hi_nxt   = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
            DIVZ: begin
                done_nxt = 1'b1;
                dz_nxt   = 1'b1;
                busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            mcand  <= '0;
            q_m1   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            q      <= q_nxt;
            mcand  <= mcand_nxt;
            q_m1   <= q_m1_nxt;
            neg_q  <= neg_q_nxt;
            neg_r  <= neg_r_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            dz_q   <= dz_nxt;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus protocol corner sequences.
module tb_mult_div_unit;
    logic clk;
    logic reset;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;      // 0 mult, 1 div, 2 both starts
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic        dz;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bus.a          = av;
        bus.b          = bv;
        bus.mult_start = (op == 2'd0) || (op == 2'd2);
        bus.div_start  = (op == 2'd1) || (op == 2'd2);
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
    endtask

    // Returns at the negedge of the done cycle; lat = edges after the start edge
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 100; n++) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                return;
            end
        end
    endtask

    initial begin
        int          lat;
        bit          bok;
        logic [31:0] h, l;
        logic        dz, bz;
        int          n_done, first;
        logic [31:0] first_lo;
        bit          seen;

        vecs[0]  = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32, 1'b0};
        vecs[1]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32, 1'b0};
        vecs[2]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32, 1'b0};
        vecs[3]  = '{2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 32, 1'b0};
        vecs[4]  = '{2'd0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32, 1'b0};
        vecs[5]  = '{2'd1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        vecs[6]  = '{2'd1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0};
        vecs[7]  = '{2'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0};
        vecs[8]  = '{2'd1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33, 1'b0};
        vecs[9]  = '{2'd1, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0};
        vecs[10] = '{2'd0, 32'd5,        32'd6,        32'd0,        32'd30,       32, 1'b0};
        vecs[11] = '{2'd1, 32'd9,        32'd0,        32'd0,        32'd30,       1,  1'b1};
        vecs[12] = '{2'd1, 32'd3,        32'd7,        32'd3,        32'd0,        33, 1'b0};
        vecs[13] = '{2'd1, 32'd5,        32'd0,        32'd3,        32'd0,        1,  1'b1};
        vecs[14] = '{2'd2, 32'd5,        32'd6,        32'd0,        32'd30,       32, 1'b0};

        reset          = 1'b1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hi",   64'(bus.hi),       64'd0);
        check("reset_lo",   64'(bus.lo),       64'd0);
        check("reset_busy", 64'(bus.busy),     64'd0);
        check("reset_done", 64'(bus.done),     64'd0);
        check("reset_dz",   64'(bus.div_zero), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bok);
            h  = bus.hi;
            l  = bus.lo;
            dz = bus.div_zero;
            bz = bus.busy;
            check($sformatf("v%0d_lat", i),     64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_hi", i),      64'(h),   64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i),      64'(l),   64'(vecs[i].lo));
            check($sformatf("v%0d_dz", i),      64'(dz),  64'(vecs[i].dz));
            check($sformatf("v%0d_busy", i),    64'(bok), 64'd1);
            check($sformatf("v%0d_busy_dn", i), 64'(bz),  64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_clr", i), 64'({bus.done, bus.div_zero}), 64'd0);
            check($sformatf("v%0d_hold_lo", i),  64'(bus.lo), 64'(vecs[i].lo));
        end

        // Re-pulsed mult_start while busy must be ignored
        start_op(2'd0, 32'h00000007, 32'hFFFFFFFD);
        n_done   = 0;
        first    = 0;
        first_lo = '0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (e == 9) begin
                bus.mult_start = 1'b1;
                bus.a          = 32'd1;
                bus.b          = 32'd1;
            end else begin
                bus.mult_start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (first == 0) begin
                    first    = e;
                    first_lo = bus.lo;
                end
            end
        end
        check("repulse_ndone", 64'(n_done),   64'd1);
        check("repulse_lat",   64'(first),    64'd32);
        check("repulse_lo",    64'(first_lo), 64'hFFFFFFEB);

        // Start accepted in the done cycle
        start_op(2'd0, 32'd3, 32'd4);
        wait_done(lat, bok);
        check("dc_first_lo", 64'(bus.lo), 64'd12);
        bus.mult_start = 1'b1;
        bus.a          = 32'd5;
        bus.b          = 32'd6;
        @(posedge clk);
        #1;
        bus.mult_start = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
        wait_done(lat, bok);
        check("dc_second_lat", 64'(lat),    64'd32);
        check("dc_second_lo",  64'(bus.lo), 64'd30);
        check("dc_second_hi",  64'(bus.hi), 64'd0);

        // Reset during a divide aborts it
        start_op(2'd1, 32'hFFFFFFF9, 32'd2);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hi",   64'(bus.hi),   64'd0);
        check("rst_mid_lo",   64'(bus.lo),   64'd0);
        check("rst_mid_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("rst_mid_quiet", 64'(seen), 64'd0);
        start_op(2'd0, 32'd3, 32'd4);
        wait_done(lat, bok);
        check("rst_after_lat", 64'(lat),    64'd32);
        check("rst_after_lo",  64'(bus.lo), 64'd12);
        check("rst_after_hi",  64'(bus.hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
